// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the self-clearing MIPS register file.
package regfile_pkg;

  localparam int unsigned REG_W    = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] ZERO_ADDR  = '0;
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_autoclr_decoder1to32.sv
// One-hot write-enable decoder; entry 0 is the hard-wired zero register and never enabled.
module decoder1to32
  import regfile_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i && addr_i != ZERO_ADDR) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_autoclr.sv
// 32x32 register file with an internal clear sequencer that zeroes entries 1..31 after
// reset or on clr_req. Define REGFILE_WR_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_autoclr
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [REG_W-1:0]  wr_data,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [REG_W-1:0]  rd1,
  output logic [REG_W-1:0]  rd2,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;

  logic                wsel_en;
  logic [ADDR_W-1:0]   wsel_addr;
  logic [REG_W-1:0]    wsel_data;
  logic [NUM_REGS-1:0] we;

  // Storage cells carry no reset; the clear sequencer establishes known contents.
  logic [REG_W-1:0]    mem_q [NUM_REGS];
  logic [REG_W-1:0]    mem_d [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= FIRST_ADDR;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = FIRST_ADDR;
        end
      end
      default: ;
    endcase
  end

  assign busy     = (state_q == ST_CLEAR);
  assign wr_ready = (state_q == ST_RUN);

  always_comb begin
    wsel_en   = wr_valid;
    wsel_addr = wr_addr;
    wsel_data = wr_data;
    if (state_q == ST_CLEAR) begin
      wsel_en   = 1'b1;
      wsel_addr = clr_cnt_q;
      wsel_data = '0;
    end
  end

  decoder1to32 u_dec (
    .addr_i   (wsel_addr),
    .en_i     (wsel_en),
    .onehot_o (we)
  );

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = we[i] ? wsel_data : mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (state_q == ST_RUN) begin
      rd1 = mem_q[ra1];
      rd2 = mem_q[ra2];
`ifdef REGFILE_WR_BYPASS_EN
      if (wr_valid && wr_addr != ZERO_ADDR) begin
        if (ra1 == wr_addr) rd1 = wr_data;
        if (ra2 == wr_addr) rd2 = wr_data;
      end
`endif
      if (ra1 == ZERO_ADDR) rd1 = '0;
      if (ra2 == ZERO_ADDR) rd2 = '0;
    end
  end

endmodule
